// File: rtl/seg7_pkg.sv
// ============================================================================
//  Module   : seg7_pkg
//  Purpose  : Shared types and the hex-to-7-segment table (a..g, a is the MSB)
//  Revision : 1.0
// ============================================================================
`default_nettype none

package seg7_pkg;

  typedef logic [0:6] seg_t;

  localparam seg_t SEG_OFF = 7'b0000000;

  localparam seg_t SEG_TABLE [16] = '{
    7'b1111110,  // 0
    7'b0110000,  // 1
    7'b1101101,  // 2
    7'b1111001,  // 3
    7'b0110011,  // 4
    7'b1011011,  // 5
    7'b1011111,  // 6
    7'b1110000,  // 7
    7'b1111111,  // 8
    7'b1111011,  // 9
    7'b1110111,  // A
    7'b0011111,  // b
    7'b1001110,  // C
    7'b0111101,  // d
    7'b1001111,  // E
    7'b1000111   // F
  };

endpackage

`default_nettype wire

// File: rtl/hex7seg_lut.sv
// ============================================================================
//  Module   : hex7seg_lut
//  Purpose  : Combinational hex nibble to active-high a..g segment pattern
//  Revision : 1.0
// ============================================================================
`default_nettype none

module hex7seg_lut
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [0:6] seg
);

  assign seg = SEG_TABLE[hex];

endmodule

`default_nettype wire

// File: rtl/seven_seg_scan.sv
// ============================================================================
//  Module   : seven_seg_scan
//  Purpose  : Time-multiplexed N-digit common-anode 7-segment driver with
//             shadow registers and an anode guard interval.
//             Define SEG7_LZ_BLANK_EN to enable leading-zero suppression.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module seven_seg_scan
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 50000,
  parameter int GUARD      = 2
)
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic                      load,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     blank,
  output logic [0:6]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     an_n,
  output logic                      frame_done
);

  localparam int c_cnt_w = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int c_idx_w = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DIV - 1);
  localparam logic [c_idx_w-1:0] c_idx_max = c_idx_w'(NUM_DIGITS - 1);

  logic [c_cnt_w-1:0]        r_cnt;
  logic [c_idx_w-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0]   r_sh_value;
  logic [NUM_DIGITS-1:0]     r_sh_dp;
  logic [NUM_DIGITS-1:0]     r_sh_blank;

  logic                      w_tick;
  logic                      w_wrap;
  logic                      w_guard;
  logic [NUM_DIGITS-1:0]     w_blank_mask;
  logic [NUM_DIGITS-1:0]     w_onehot;
  logic [3:0]                w_nibble;
  logic                      w_blank_cur;
  logic                      w_dp_cur;
  logic [0:6]                w_lut_seg;

  assign w_tick = (r_cnt == c_cnt_max);
  assign w_wrap = w_tick && (r_idx == c_idx_max);

  // Prescaler and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      frame_done <= 1'b0;
    end else begin
      r_cnt      <= w_tick ? '0 : r_cnt + c_cnt_w'(1);
      frame_done <= w_wrap;
      if (w_tick) begin
        r_idx <= (r_idx == c_idx_max) ? '0 : r_idx + c_idx_w'(1);
      end
    end
  end

  // Shadow registers; the output stage sees new data from the following edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_value <= '0;
      r_sh_dp    <= '0;
      r_sh_blank <= '0;
    end else if (load) begin
      r_sh_value <= value;
      r_sh_dp    <= dp_in;
      r_sh_blank <= blank;
    end
  end

  generate
    if (GUARD > 0) begin : g_guard
      localparam logic [c_cnt_w-1:0] c_guard = c_cnt_w'(GUARD);
      assign w_guard = (r_cnt < c_guard);
    end else begin : g_no_guard
      assign w_guard = 1'b0;
    end
  endgenerate

`ifdef SEG7_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] w_lz;
  logic                  w_zero_above;

  // Walk down from the top nibble; digit 0 is never suppressed
  always_comb begin
    w_lz         = '0;
    w_zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      w_zero_above = w_zero_above & (r_sh_value[k*4 +: 4] == 4'h0);
      w_lz[k]      = w_zero_above;
    end
  end

  assign w_blank_mask = r_sh_blank | w_lz;
`else
  assign w_blank_mask = r_sh_blank;
`endif

  // Select the current digit's nibble, dp and blank bits
  always_comb begin
    w_nibble    = 4'h0;
    w_blank_cur = 1'b0;
    w_dp_cur    = 1'b0;
    w_onehot    = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == c_idx_w'(k)) begin
        w_nibble    = r_sh_value[k*4 +: 4];
        w_blank_cur = w_blank_mask[k];
        w_dp_cur    = r_sh_dp[k];
        w_onehot[k] = 1'b1;
      end
    end
  end

  hex7seg_lut u_lut (
    .hex (w_nibble),
    .seg (w_lut_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg  <= SEG_OFF;
      dp   <= 1'b0;
      an_n <= '1;
    end else begin
      seg  <= w_blank_cur ? SEG_OFF : w_lut_seg;
      dp   <= w_dp_cur & ~w_blank_cur;
      an_n <= (w_guard | w_blank_cur) ? '1 : ~w_onehot;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
// ============================================================================
//  Module   : tb_seven_seg_scan
//  Purpose  : Randomised self-checking bench with an arithmetic scan model
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seven_seg_scan;

  localparam int N  = 4;
  localparam int DV = 4;
  localparam int GD = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank = '0;
  logic [0:6]  seg;
  logic        dp;
  logic [3:0]  an_n;
  logic        frame_done;

  int vectors = 0;
  int miscompares = 0;

  seven_seg_scan #(.NUM_DIGITS(N), .DIV(DV), .GUARD(GD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .load       (load),
    .dp_in      (dp_in),
    .blank      (blank),
    .seg        (seg),
    .dp         (dp),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  logic [6:0] lut [0:15] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  // Model: edge e after reset release scans slot (e/DV)%N at offset e%DV
  int          e;
  logic [15:0] m_val;
  logic [3:0]  m_dp, m_blank;
  logic [6:0]  x_seg;
  logic        x_dp, x_fd;
  logic [3:0]  x_an;
  bit          m_valid = 0;

  function automatic bit lz_blank(input logic [15:0] v, input int d);
`ifdef SEG7_LZ_BLANK_EN
    return (d > 0) && ((v >> (4 * d)) == 16'h0);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e = 0; m_val = '0; m_dp = '0; m_blank = '0;
      x_seg = '0; x_dp = 0; x_an = 4'hF; x_fd = 0;
      m_valid = 1;
    end else begin
      int c, d;
      bit bl;
      c  = e % DV;
      d  = (e / DV) % N;
      bl = m_blank[d] | lz_blank(m_val, d);
      x_an  = (c < GD || bl) ? 4'hF : ~(4'b0001 << d);
      x_seg = bl ? 7'b0 : lut[(m_val >> (4 * d)) & 16'hF];
      x_dp  = m_dp[d] & ~bl;
      x_fd  = (e % (DV * N)) == (DV * N - 1);
      if (load) begin
        m_val = value; m_dp = dp_in; m_blank = blank;
      end
      e++;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      vectors++;
      if ({seg, dp, an_n, frame_done} !== {x_seg, x_dp, x_an, x_fd}) begin
        miscompares++;
        $display("FAIL scan t=%0t got seg=%b dp=%b an_n=%b fd=%b want seg=%b dp=%b an_n=%b fd=%b",
                 $time, seg, dp, an_n, frame_done, x_seg, x_dp, x_an, x_fd);
      end
    end
  end

  task automatic pin(input string nm, input logic [11:0] got, input logic [11:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%b want=%b", nm, got, want);
    end
  endtask

  // Returns at the negedge where frame_done is seen high
  task automatic wait_frame();
    bit seen;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL frame_timeout got=0 want=1");
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    @(negedge clk);
    load = 1; value = v; dp_in = d; blank = b;
    @(negedge clk);
    load = 0;
  endtask

  // Check the second cycle of each slot of the next frame against literals
  task automatic check_frame(input string nm, input logic [6:0] s0, s1, s2, s3,
                             input logic [3:0] a0, a1, a2, a3);
    logic [6:0] s [4];
    logic [3:0] a [4];
    s = '{s0, s1, s2, s3};
    a = '{a0, a1, a2, a3};
    wait_frame();
    @(posedge clk); #1;
    pin({nm, "_guard"}, {8'h0, an_n}, {8'h0, 4'hF});
    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin
        @(posedge clk); #1;
      end else begin
        repeat (4) @(posedge clk);
        #1;
      end
      pin($sformatf("%s_dig%0d", nm, k), {1'b0, seg, an_n}, {1'b0, s[k], a[k]});
    end
  endtask

  initial begin
    int fd_cnt, prev_fd, dbl;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    pin("rst_guard", {8'h0, an_n}, {8'h0, 4'hF});
    @(posedge clk); #1;
    pin("rst_dig0", {1'b0, seg, an_n}, {1'b0, 7'b1111110, 4'b1110});

    do_load(16'h12AF, 4'b0000, 4'b0000);
    check_frame("hex12af", 7'b1000111, 7'b1110111, 7'b1101101, 7'b0110000,
                4'b1110, 4'b1101, 4'b1011, 4'b0111);

    fd_cnt = 0; prev_fd = 0; dbl = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (frame_done) fd_cnt++;
      if (frame_done && prev_fd) dbl++;
      prev_fd = frame_done;
    end
    pin("fd_count", 12'(fd_cnt), 12'd4);
    pin("fd_double", 12'(dbl), 12'd0);

    do_load(16'h12AF, 4'b0001, 4'b0100);
    wait_frame();
    @(posedge clk); @(posedge clk); #1;
    pin("dp_dig0", {11'h0, dp}, {11'h0, 1'b1});
    repeat (8) @(posedge clk);
    #1;
    pin("blank_dig2", {seg, dp, an_n}, {7'b0, 1'b0, 4'hF});

    do_load(16'h0050, 4'b0000, 4'b0000);
`ifdef SEG7_LZ_BLANK_EN
    check_frame("lz0050", 7'b1111110, 7'b1011011, 7'b0000000, 7'b0000000,
                4'b1110, 4'b1101, 4'b1111, 4'b1111);
    do_load(16'h0000, 4'b0000, 4'b0000);
    check_frame("lz0000", 7'b1111110, 7'b0000000, 7'b0000000, 7'b0000000,
                4'b1110, 4'b1111, 4'b1111, 4'b1111);
`else
    check_frame("v0050", 7'b1111110, 7'b1011011, 7'b1111110, 7'b1111110,
                4'b1110, 4'b1101, 4'b1011, 4'b0111);
`endif

    // Asynchronous reset in the middle of a slot
    repeat (6) @(posedge clk);
    #2 rst_n = 0;
    #1 pin("async_rst", {seg, dp, an_n}, {7'b0, 1'b0, 4'hF});
    pin("async_rst_fd", {11'h0, frame_done}, 12'h0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    pin("rerst_guard", {8'h0, an_n}, {8'h0, 4'hF});
    @(posedge clk); #1;
    pin("rerst_dig0", {1'b0, seg, an_n}, {1'b0, 7'b1111110, 4'b1110});

    // Random traffic against the model
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      load  = ($urandom_range(0, 5) == 0) || (i >= 600 && i < 620);
      value = 16'($urandom);
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 1) == 1) value[k*4 +: 4] = 4'h0;
      end
      dp_in = 4'($urandom);
      blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 0;
        @(negedge clk);
        #2 rst_n = 1;
      end
    end
    load = 0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
Parametrised, time-multiplexed driver for an N-digit common-anode 7-segment display. It latches an N-nibble hex value into a shadow register and scans the digits one at a time from a clock-derived refresh tick. Each digit's segments come from the team's hex-to-7-segment table, and an anode guard interval suppresses ghosting. It sits between datapath/debug registers and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
DIV, 50000, clock cycles per digit slot (>=2)
GUARD, 2, cycles at the start of each slot with all anodes off (0 <= GUARD < DIV)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
value  input  4*NUM_DIGITS  hex digits; nibble k drives digit k (digit 0 = rightmost)
load  input  1  on a high clk edge, value/dp_in/blank are copied to the shadow registers
dp_in  input  NUM_DIGITS  decimal point per digit, 1 = on
blank  input  NUM_DIGITS  per-digit force-off, 1 = blanked
seg  output  [0:6]  segments a..g, seg[0] = a, active-high (1 = lit)
dp  output  1  decimal point of the current digit, active-high
an_n  output  NUM_DIGITS  one-hot-low anode enables
frame_done  output  1  one-cycle pulse when a full scan completes

Behaviour:
- Clocking: one clock. Reset is asynchronous and active-low, named rst_n. Clock port is clk.
- Reset values: seg=0, dp=0, an_n=all 1s, frame_done=0, prescaler cnt=0, digit index idx=0, shadow value/dp/blank=0.
- Prescaler: cnt counts 0..DIV-1, then wraps to 0. tick = (cnt==DIV-1).
  - cnt width is $clog2(DIV), min 1.
- Digit index: on tick, idx advances (NUM_DIGITS-1 wraps to 0).
  - frame_done is registered. It is 1 in the cycle after the wrap edge, otherwise 0.
  - NUM_DIGITS=1: idx stays 0, and frame_done pulses every DIV cycles.
- Output register (1-cycle latency from cnt/idx):
  - an_n <= all 1s if cnt < GUARD or shadow_blank[idx]=1; otherwise ~(1<<idx).
  - seg <= 0 if shadow_blank[idx]; otherwise hex_lut(shadow_value nibble idx).
  - dp <= shadow_dp[idx] & ~shadow_blank[idx].
- Shadow load: on a clk edge with load=1, all three shadows update. The output register at that same edge still uses the old shadow; the new data appears from the next edge onward. load held high means continuous update. Load never disturbs cnt or idx.
- Segment table (a..g):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
- Reset mid-scan: all state returns to reset values immediately (asynchronous). Scanning restarts at digit 0, cnt 0 after release. The shadow is cleared, so the display shows "0" digits until the next load.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
Macro SEG7_LZ_BLANK_EN enables leading-zero suppression.
- Defined: a digit k>0 is blanked if it and every higher nibble of the shadow value are 0 (ORed with shadow_blank). Digit 0 is never auto-blanked. The mask is computed combinationally from the shadow and applied at the output register.
- Undefined: only the explicit blank input blanks digits, and no suppression logic is generated.

Decomposition:
- Package seg7_pkg holds:
  - typedef seg_t = logic [0:6]
  - localparam SEG_OFF = 7'b0
  - the 16-entry segment constant array above
- Sub-module hex7seg_lut is purely combinational: 4-bit hex in, seg_t out, built from the package table. It is instantiated once on the muxed nibble.
- seven_seg_scan holds the prescaler, index, shadow, blanking and output registers.

Test Plan:
1. Assert rst_n=0 mid-slot -> the same cycle gives seg=0000000, an_n=1111, dp=0, frame_done=0. After release, the first digit-0 enable (an_n=1110) appears GUARD+1 cycles later.
2. NUM_DIGITS=4, DIV=4, GUARD=1, load value=16'h12AF -> per slot:
   - digit0: seg=1000111, an_n=1110
   - digit1: seg=1110111, an_n=1101
   - digit2: seg=1101101, an_n=1011
   - digit3: seg=0110000, an_n=0111
   - the first cycle of each slot has an_n=1111
3. Same configuration, free-running -> frame_done high exactly 1 cycle in every 16, and never two in a row.
4. load with blank=4'b0100 and dp_in=4'b0001 -> the digit2 slot has an_n=1111, seg=0000000, dp=0. The digit0 slot has dp=1.
5. load issued on the same edge as a slot's first output update -> that slot still shows the old nibble for 1 cycle, then the new one. idx is unaffected.
6. With SEG7_LZ_BLANK_EN:
   - value=16'h0050 -> digits 3 and 2 dark; digit1 shows 1011011, digit0 shows 1111110
   - value=16'h0000 -> only digit0 lit, showing 1111110
